bus_read_switch_port: RTL

Bus-facing read port for the eight slide switches: synchronises and debounces them, latches rising edges into sticky flags and raises a masked level interrupt. The microprocessor reads results over the shared 8-bit data bus. It is the read-direction counterpart to the write-only output registers (seven-seg, LEDs) on the same bus and follows the same address/write-enable protocol. Read data is registered and driven with an output enable, one cycle after the address.

---
 rtl/bus_read_switch_port_pkg.sv | 37 +++
 rtl/bus_read_switch_port_input_debouncer.sv | 63 ++++++
 rtl/bus_read_switch_port.sv | 110 +++++++++++
 3 files changed

// File: rtl/bus_read_switch_port_pkg.sv
// Shared definitions for the switch read port: register offsets, widths, bus payload and decode helper.
package bus_read_switch_port_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 4;

   localparam logic [DATA_W-1:0] OFF_STATE = 8'd0;
   localparam logic [DATA_W-1:0] OFF_FLAGS = 8'd1;
   localparam logic [DATA_W-1:0] OFF_MASK  = 8'd2;

   typedef struct packed {
      logic [DATA_W-1:0] addr;
      logic              we;
      logic [DATA_W-1:0] wdata;
   } bus_req_t;

   typedef enum logic [1:0] {
      REG_STATE = 2'd0,
      REG_FLAGS = 2'd1,
      REG_MASK  = 2'd2,
      REG_NONE  = 2'd3
   } reg_sel_t;

   // Window decode; offsets are taken modulo the bus width so the window may sit anywhere.
   function automatic reg_sel_t decode(input logic [DATA_W-1:0] addr,
                                       input logic [DATA_W-1:0] base);
      logic [DATA_W-1:0] off;
      off = addr - base;
      case (off)
         OFF_STATE: decode = REG_STATE;
         OFF_FLAGS: decode = REG_FLAGS;
         OFF_MASK:  decode = REG_MASK;
         default:   decode = REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/bus_read_switch_port_input_debouncer.sv
// One-bit switch conditioner: two-flop synchroniser followed by a tick-sampled debouncer.
// Macro DEBOUNCE_EN selects the counting debouncer; otherwise the level is the synchroniser output registered once.
module input_debouncer
   import bus_read_switch_port_pkg::*;
#(
   parameter int unsigned SAMPLES = 4
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic TICK,
   input  logic RAW,
   output logic LEVEL
);

   logic sync1;
   logic sync2;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= RAW;
         sync2 <= sync1;
      end
   end

`ifdef DEBOUNCE_EN
   logic [CNT_W-1:0] cnt;

   // Count ticks of disagreement; flip once SAMPLES consecutive ticks disagree.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt   <= '0;
         LEVEL <= 1'b0;
      end else if (TICK) begin
         if (sync2 != LEVEL) begin
            if (cnt == CNT_W'(SAMPLES - 1)) begin
               LEVEL <= ~LEVEL;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end
`else
   logic unused_tick;
   localparam bit unused_cfg = (SAMPLES >= 1);
   assign unused_tick = TICK ^ unused_cfg;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         LEVEL <= 1'b0;
      end else begin
         LEVEL <= sync2;
      end
   end
`endif

endmodule

// File: rtl/bus_read_switch_port.sv
// Bus read port for eight slide switches: debounced STATE, sticky rising-edge FLAGS, MASK and masked IRQ.
// Macro DEBOUNCE_EN enables the shared prescaler and per-bit debounce counters.
module bus_read_switch_port
   import bus_read_switch_port_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDR        = 8'hE0,
   parameter int unsigned DEBOUNCE_DIV     = 1000,
   parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [DATA_W-1:0] BUS_ADDR,
   input  logic              BUS_WE,
   input  logic [DATA_W-1:0] BUS_DATA_IN,
   output logic [DATA_W-1:0] BUS_DATA_OUT,
   output logic              BUS_DATA_OE,
   input  logic [DATA_W-1:0] SWITCHES,
   output logic              IRQ
);

   bus_req_t          req;
   reg_sel_t          sel_c;
   logic              tick;
   logic [DATA_W-1:0] level;
   logic [DATA_W-1:0] level_q;
   logic [DATA_W-1:0] flags_q;
   logic [DATA_W-1:0] mask_q;
   logic [DATA_W-1:0] rise_c;
   logic [DATA_W-1:0] clr_c;
   logic [DATA_W-1:0] rdata_c;

   assign req   = '{addr: BUS_ADDR, we: BUS_WE, wdata: BUS_DATA_IN};
   assign sel_c = decode(req.addr, BASE_ADDR);

`ifdef DEBOUNCE_EN
   localparam int unsigned PRE_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
   logic [PRE_W-1:0] presc;

   // Free-running prescaler shared by all bits; tick on terminal count.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         presc <= '0;
      end else if (presc == PRE_W'(DEBOUNCE_DIV - 1)) begin
         presc <= '0;
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

   assign tick = (presc == PRE_W'(DEBOUNCE_DIV - 1));
`else
   localparam bit unused_div = (DEBOUNCE_DIV >= 2);
   assign tick = unused_div & 1'b0;
`endif

   for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      input_debouncer #(
         .SAMPLES(DEBOUNCE_SAMPLES)
      ) u_deb (
         .CLK    (CLK),
         .RESET_N(RESET_N),
         .TICK   (tick),
         .RAW    (SWITCHES[i]),
         .LEVEL  (level[i])
      );
   end

   // Edge detect, write-1-clear and read mux.
   always_comb begin
      rise_c  = level & ~level_q;
      clr_c   = '0;
      rdata_c = '0;
      if (req.we && (sel_c == REG_FLAGS)) begin
         clr_c = req.wdata;
      end
      case (sel_c)
         REG_STATE: rdata_c = level;
         REG_FLAGS: rdata_c = flags_q;
         REG_MASK:  rdata_c = mask_q;
         default:   rdata_c = '0;
      endcase
   end

   // Set takes priority over clear when both hit the same flag bit.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         level_q      <= '0;
         flags_q      <= '0;
         mask_q       <= '0;
         IRQ          <= 1'b0;
         BUS_DATA_OUT <= '0;
         BUS_DATA_OE  <= 1'b0;
      end else begin
         level_q <= level;
         flags_q <= (flags_q & ~clr_c) | rise_c;
         IRQ     <= |(flags_q & mask_q);
         if (req.we && (sel_c == REG_MASK)) begin
            mask_q <= req.wdata;
         end
         if (!req.we && (sel_c != REG_NONE)) begin
            BUS_DATA_OE  <= 1'b1;
            BUS_DATA_OUT <= rdata_c;
         end else begin
            BUS_DATA_OE  <= 1'b0;
            BUS_DATA_OUT <= '0;
         end
      end
   end

endmodule
